// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer built around a single 1-bit full adder.
// One result bit is produced per clock, LSB first, behind a start/busy/done
// handshake.

// 1-bit full adder cell, time-multiplexed by the sequencer below.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    // Sum and carry of three input bits.
    always_comb begin
        Y    = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
    end

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_y;
    logic             fa_cout;

    Full_Adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .Y    (fa_y),
        .Cout (fa_cout)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath control: capture in IDLE, one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert B and seed the carry with 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_y, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Park the counter at zero so it never passes WIDTH-1.
                    cnt_d   = '0;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole result is computed arithmetically on
    // acceptance; during the run the low k result bits sit at the top of sum.
    logic         m_busy, m_done, m_cout;
    logic [W-1:0] m_sum;
    logic [W:0]   m_res;
    int           m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cout <= 1'b0;
            m_sum  <= '0;
            m_res  <= '0;
            m_k    <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_k   <= m_k + 1;
            m_sum <= m_res[W-1:0] << (W - (m_k + 1));
            if (m_k + 1 == W) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_cout <= m_res[W];
                m_k    <= 0;
            end
        end else if (start) begin
            if (sub)
                m_res <= {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            else
                m_res <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m_busy <= 1'b1;
            m_k    <= 0;
            m_sum  <= '0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("sum",  sum,  m_sum);
            check("cout", cout, m_cout);
        end
    end

    // Directed operation with literal expectations; entered at a negedge in IDLE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic inject);
        int n;
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        if (inject) begin
            @(negedge clk); n++;
            @(negedge clk); n++;
            start = 1'b1; a = 8'hAA; b = 8'h55;
            @(negedge clk); n++;
            start = 1'b0;
        end
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, W + 1);
        check("op_sum", sum, es);
        check("op_cout", cout, ec);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dcnt;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum",  sum,  8'h00);
        check("rst_cout", cout, 1'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        do_op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        do_op(8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1);
        do_op(8'h20, 8'h22, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0);

        // Reset four cycles into RUN.
        a = 8'h35; b = 8'h4A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_sum",  sum,  8'h00);
        check("arst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Back-to-back: start held high for 30 edges gives accepts every W+2.
        dcnt = 0;
        start = 1'b1;
        repeat (30) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (done) dcnt++;
        end
        start = 1'b0;
        check("b2b_dones", dcnt, 3);
        repeat (3) @(negedge clk);

        // Random traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            a = W'($urandom); b = W'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            if (i == 250) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        start = 1'b0;
        repeat (3 * W) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing a single instance of the team's 1-bit Full_Adder cell, one bit per clock, LSB first.
- Provides a start/busy/done handshake, operand capture, a carry flip-flop, a bit counter and result assembly.
- Serves as the area-minimal arithmetic unit for slow-path datapaths in the design.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; ignored when sub=1; captured with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  single-cycle pulse when the result is complete.
- sum  output  WIDTH  result register.
- cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. No other clocks. Reset asserted forces, immediately and independent of clk: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry FF=0, operand shift registers=0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at a rising edge: load shift register A<=a and B<=(sub ? ~b : b).
  - Carry FF <= (sub ? 1 : cin); counter<=0; state<=RUN.
  - sum and cout keep their previous values until that edge; sum is cleared to 0 on acceptance.
- RUN:
  - busy=1, done=0.
  - Full_Adder inputs are A[0], B[0] and the carry FF.
  - Each edge:
    - sum <= {fa_Y, sum[WIDTH-1:1]};
    - A and B shift right by one;
    - carry FF <= fa_Cout;
    - counter++.
  - On the edge where counter==WIDTH-1: cout<=fa_Cout, state<=DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle; sum and cout hold the final result.
  - Next edge: state<=IDLE unconditionally.
- Latency: start accepted at edge E0; done is high during the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after acceptance. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored (no queuing). The operand, sub and cin inputs are don't-care outside the accepting edge.
- sum is only valid when done=1 and afterwards in IDLE; during RUN it holds partial (shifting) bits.
- Arithmetic is modulo 2^WIDTH: add gives a+b+cin; subtract gives a+~b+1. Overflow is not flagged; the carry out of the MSB is reported on cout only.
- Reset mid-operation aborts with no done pulse. All outputs go to their reset values. The first start after rst_n deasserts behaves normally.
- The counter width is clog2(WIDTH) and it never exceeds WIDTH-1.

Test Plan:
- WIDTH=8, add: a=0x35, b=0x4A, cin=0 -> busy for 8 cycles; done on the 9th edge after acceptance; sum=0x7F, cout=0.
- Add wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Subtract: sub=1, a=0x10, b=0x01, cin=1 (ignored) -> sum=0x0F, cout=1. Then a=0x00, b=0x01 -> sum=0xFF, cout=0 (borrow).
- Start during busy: start a=0x01, b=0x02; reassert start with a=0xAA, b=0x55 at cycle 3 of RUN -> ignored; result sum=0x03, exactly one done pulse; next start in IDLE is accepted.
- Reset mid-run: assert rst_n=0 asynchronously 4 cycles into RUN -> busy, done, sum and cout go to 0 immediately with no done pulse. After release, a=0x12, b=0x34 -> sum=0x46, cout=0.
- Back-to-back: start held high continuously -> operations accepted only in IDLE, one every 10 cycles; sum/cout remain stable between done and the next acceptance.
